ct_poly_add: RTL and testbench
==============================

Name: ct_poly_add

Overview:
- Downstream stage of the polynomial multiplier. Consumes the product stream z (one QW-bit coefficient per cycle) and an error-polynomial stream e.
- Emits ciphertext coefficients c[i] = (z[i] + e[i]) mod Q as an AXI-stream.
- The multiplier ignores z_rdy, so this block must absorb z unconditionally. It buffers z in an N-deep FIFO until the matching e coefficient and output slot are available.

Parameters:
- N, 16: coefficients per polynomial; power of two, >= 2; also the z FIFO depth.
- QW, 64: coefficient bit-width.
- Q, 64'hFFFFFFFF00000001: modulus, QW bits, must be > 1.

Ports:
- clk  in  1  clock
- s_rst_n  in  1  asynchronous active-low reset
- z_vld  in  1  product coefficient valid
- z_rdy  out  1  high when FIFO not full (advisory only; upstream ignores it)
- z  in  QW  product coefficient, required < Q
- z_last  in  1  last coefficient of product polynomial
- e_vld  in  1  error coefficient valid
- e_rdy  out  1  error coefficient accepted
- e  in  QW  error coefficient, required < Q
- e_last  in  1  last coefficient of error polynomial
- c_vld  out  1  result valid
- c_rdy  in  1  downstream ready
- c  out  QW  result coefficient
- c_last  out  1  last coefficient of result polynomial
- err_ovf  out  1  sticky: z beat arrived while FIFO full
- err_last  out  1  sticky: z_last/e_last misaligned with coefficient counter
- err_range  out  1  sticky input-range error (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FIFO empty; pointers and coefficient counter = 0.
  - All pipeline valids = 0.
  - c_vld = 0, c = 0, c_last = 0.
  - All err_* = 0; z_rdy = 1; e_rdy = 0.
- FIFO:
  - Write on z_vld. When full, the beat is dropped, err_ovf sets and holds until reset.
  - FIFO entry = {z_last, z}.
  - Read and write in the same cycle while full: read frees a slot first, so the write succeeds.
  - z_rdy = !full.
- Join:
  - Beat fires when FIFO non-empty AND e_vld AND stage-1 can advance.
  - Stage-1 can advance when stage-1 is empty, or stage-2 is empty, or c_rdy.
  - e_rdy = FIFO non-empty AND stage-1 can advance. e_rdy never depends combinationally on c_vld.
  - On fire: pop FIFO, consume e.
- Stage 1 registers:
  - sum = z + e, QW+1 bits.
  - Last flag from coefficient counter (cnt == N-1).
- Stage 2 registers:
  - c = (sum >= Q) ? sum - Q : sum, truncated to QW.
  - c_last = stage-1 last flag.
- Latency: 2 cycles from fire to c_vld with no stall. Throughput: 1 coefficient/cycle.
- Output handshake:
  - c, c_last held stable while c_vld && !c_rdy.
  - Pipeline stalls as a whole; no beat lost or duplicated.
- Coefficient counter:
  - Increments on each fire; wraps N-1 -> 0.
  - c_last is derived from the counter, not from inputs.
  - On fire, if popped z_last != (cnt == N-1) or e_last != (cnt == N-1), err_last sets. Data still passes.
- Reset mid-polynomial: all in-flight and buffered data discarded; counter restarts at 0.
- Inputs >= Q: result undefined, no hang (modulo reduces at most once).

Optional Feature:
- Macro CT_INPUT_RANGE_CHK_EN.
- Defined: on each fire, err_range sets if z >= Q or e >= Q. The beat still passes, result unspecified.
- Undefined: no comparators; err_range tied 0.

Test Plan:
- N=4, QW=8, Q=251, c_rdy=1; z={10,20,30,40}, e={1,2,3,4} aligned -> c={11,22,33,44} at 2-cycle latency; c_last only on 44; no errors.
- Wrap: z=250, e=250 -> c=249. z=200, e=51 -> c=0. z=0, e=0 -> c=0.
- Backpressure:
  - z burst of 4 with e_vld=0 -> FIFO full, z_rdy=0, no loss.
  - Then e supplied and c_rdy toggled 1,0,0,1,... -> c values stable during stalls, all 4 emitted in order exactly once.
- Overflow: 5 consecutive z beats with e_vld=0 -> err_ovf=1 after beat 5. The first 4 coefficients later emerge correctly.
- Misalignment: z_last asserted on coefficient index 2 -> err_last=1 at that fire; c_last still on index 3.
- With CT_INPUT_RANGE_CHK_EN: e=251 -> err_range=1. Without macro -> err_range stays 0.
- Async reset asserted after 2 of 4 coefficients fired -> outputs return to reset values immediately. The next polynomial starts at counter 0 with correct c_last.

Source files
------------

// File: rtl/ct_poly_add.sv
// ct_poly_add: c[i] = (z[i] + e[i]) mod Q over a z FIFO, a two-stage add/reduce pipeline and an AXI-stream output.
// Define CT_INPUT_RANGE_CHK_EN to build the z/e >= Q range checker that drives err_range.
module ct_poly_add #(
    parameter int unsigned    N  = 16,
    parameter int unsigned    QW = 64,
    parameter logic [QW-1:0]  Q  = 64'hFFFFFFFF00000001
) (
    input  logic          clk,
    input  logic          s_rst_n,
    input  logic          z_vld,
    output logic          z_rdy,
    input  logic [QW-1:0] z,
    input  logic          z_last,
    input  logic          e_vld,
    output logic          e_rdy,
    input  logic [QW-1:0] e,
    input  logic          e_last,
    output logic          c_vld,
    input  logic          c_rdy,
    output logic [QW-1:0] c,
    output logic          c_last,
    output logic          err_ovf,
    output logic          err_last,
    output logic          err_range
);

    localparam int unsigned   PW       = $clog2(N);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(N);
    localparam logic [QW:0]   Q_EXT    = {1'b0, Q};

    logic [QW:0]   mem_q [N];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          s1_vld_q, s1_vld_d;
    logic [QW:0]   s1_sum_q, s1_sum_d;
    logic          s1_last_q, s1_last_d;
    logic          s2_vld_q, s2_vld_d;
    logic [QW-1:0] c_q, c_d;
    logic          c_last_q, c_last_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_last_q, err_last_d;

    logic          fifo_empty, fifo_full;
    logic          s1_adv, s2_adv;
    logic          fire, push;
    logic [QW:0]   head;
    logic [QW-1:0] head_z;
    logic          head_last;
    logic          cnt_is_last;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == FULL_CNT);
    assign s2_adv      = !s2_vld_q || c_rdy;
    assign s1_adv      = !s1_vld_q || s2_adv;
    assign head        = mem_q[rd_ptr_q];
    assign head_z      = head[QW-1:0];
    assign head_last   = head[QW];
    assign cnt_is_last = (cnt_q == LAST_IDX);

    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign fire = !fifo_empty && e_vld && s1_adv;
    assign push = z_vld && (!fifo_full || fire);

    assign z_rdy    = !fifo_full;
    assign e_rdy    = !fifo_empty && s1_adv;
    assign c_vld    = s2_vld_q;
    assign c        = c_q;
    assign c_last   = c_last_q;
    assign err_ovf  = err_ovf_q;
    assign err_last = err_last_q;

`ifdef CT_INPUT_RANGE_CHK_EN
    logic err_range_q, err_range_d;

    always_comb begin
        err_range_d = err_range_q;
        if (fire && ((head_z >= Q) || (e >= Q))) begin
            err_range_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            err_range_q <= 1'b0;
        end else begin
            err_range_q <= err_range_d;
        end
    end

    assign err_range = err_range_q;
`else
    assign err_range = 1'b0;
`endif

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, fire};
        cnt_d      = cnt_q;
        s1_vld_d   = s1_vld_q;
        s1_sum_d   = s1_sum_q;
        s1_last_d  = s1_last_q;
        s2_vld_d   = s2_vld_q;
        c_d        = c_q;
        c_last_d   = c_last_q;
        err_ovf_d  = err_ovf_q;
        err_last_d = err_last_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (z_vld && fifo_full && !fire) begin
            err_ovf_d = 1'b1;
        end

        if (fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = cnt_is_last ? '0 : cnt_q + PW'(1);
            if ((head_last != cnt_is_last) || (e_last != cnt_is_last)) begin
                err_last_d = 1'b1;
            end
        end

        if (s1_adv) begin
            s1_vld_d = fire;
            if (fire) begin
                s1_sum_d  = {1'b0, head_z} + {1'b0, e};
                s1_last_d = cnt_is_last;
            end
        end

        // Subtracting in QW bits is exact because a reduced sum always fits in QW bits.
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                c_d      = (s1_sum_q >= Q_EXT) ? (s1_sum_q[QW-1:0] - Q) : s1_sum_q[QW-1:0];
                c_last_d = s1_last_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {z_last, z};
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_sum_q   <= '0;
            s1_last_q  <= 1'b0;
            s2_vld_q   <= 1'b0;
            c_q        <= '0;
            c_last_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_last_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_sum_q   <= s1_sum_d;
            s1_last_q  <= s1_last_d;
            s2_vld_q   <= s2_vld_d;
            c_q        <= c_d;
            c_last_q   <= c_last_d;
            err_ovf_q  <= err_ovf_d;
            err_last_q <= err_last_d;
        end
    end

endmodule

// File: tb/tb_ct_poly_add.sv
// tb_ct_poly_add: directed and randomized checks of ct_poly_add (N=4, QW=8, Q=251) against a queue-based model.
// The expected err_range follows CT_INPUT_RANGE_CHK_EN in the same way as the design.
module tb_ct_poly_add;

    localparam int N  = 4;
    localparam int QW = 8;
    localparam int Q  = 251;

    logic          clk;
    logic          s_rst_n;
    logic          z_vld, z_rdy, z_last;
    logic [QW-1:0] z;
    logic          e_vld, e_rdy, e_last;
    logic [QW-1:0] e;
    logic          c_vld, c_rdy, c_last;
    logic [QW-1:0] c;
    logic          err_ovf, err_last, err_range;

    ct_poly_add #(.N(N), .QW(QW), .Q(8'd251)) dut (
        .clk(clk), .s_rst_n(s_rst_n),
        .z_vld(z_vld), .z_rdy(z_rdy), .z(z), .z_last(z_last),
        .e_vld(e_vld), .e_rdy(e_rdy), .e(e), .e_last(e_last),
        .c_vld(c_vld), .c_rdy(c_rdy), .c(c), .c_last(c_last),
        .err_ovf(err_ovf), .err_last(err_last), .err_range(err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [QW-1:0] val;
        logic          last;
        bit            dc;
        int            fireCyc;
    } exp_t;

    exp_t          expQ[$];
    logic [QW:0]   zModel[$];
    logic [QW-1:0] ePendV[$];
    logic          ePendL[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int fireIdx = 0;
    bit eEn = 1'b0;
    bit latChk = 1'b0;
    bit ovfExp = 1'b0;
    bit lastExp = 1'b0;
    bit rangeExp = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pushE(input int v, input bit l);
        ePendV.push_back(QW'(v));
        ePendL.push_back(l);
    endtask

    // One clock cycle: drive inputs, score the handshakes seen before the edge, then check sticky flags.
    task automatic applyStimulus(input bit zv, input logic [QW-1:0] zd, input bit zl, input bit crdy);
        bit            eFire;
        bit            oFire;
        bit            lastIdx;
        logic [QW:0]   zh;
        logic [QW-1:0] eVal;
        exp_t          ex;
        z_vld = zv;
        z     = zd;
        z_last = zl;
        c_rdy = crdy;
        if (eEn && ePendV.size() > 0) begin
            e_vld = 1'b1; e = ePendV[0]; e_last = ePendL[0];
        end else begin
            e_vld = 1'b0; e = '0; e_last = 1'b0;
        end
        #1;
        checkOutput("z_rdy", z_rdy, zModel.size() < N);
        if (zModel.size() == 0) checkOutput("e_rdy_empty", e_rdy, 0);
        eFire = e_vld && e_rdy;
        oFire = c_vld && crdy;
        eVal  = e;
        if (c_vld) begin
            if (expQ.size() == 0) begin
                checkOutput("c_unexpected", c_vld, 0);
            end else begin
                if (!expQ[0].dc) checkOutput(oFire ? "c_data" : "c_stall_data", c, expQ[0].val);
                checkOutput("c_last", c_last, expQ[0].last);
                if (latChk && oFire) checkOutput("latency", cycle - expQ[0].fireCyc, 2);
                if (oFire) void'(expQ.pop_front());
            end
        end
        if (eFire) begin
            lastIdx = ((fireIdx % N) == N - 1);
            zh = (zModel.size() > 0) ? zModel.pop_front() : '0;
            ex.val     = QW'((int'(zh[QW-1:0]) + int'(eVal)) % Q);
            ex.last    = lastIdx;
            ex.dc      = (zh[QW-1:0] >= Q) || (eVal >= Q);
            ex.fireCyc = cycle;
            expQ.push_back(ex);
            if ((zh[QW] != lastIdx) || (e_last != lastIdx)) lastExp = 1'b1;
`ifdef CT_INPUT_RANGE_CHK_EN
            if (ex.dc) rangeExp = 1'b1;
`endif
            void'(ePendV.pop_front());
            void'(ePendL.pop_front());
            fireIdx++;
        end
        if (zv) begin
            if (zModel.size() < N) zModel.push_back({zl, zd});
            else ovfExp = 1'b1;
        end
        @(posedge clk);
        #1;
        cycle++;
        checkOutput("err_ovf", err_ovf, ovfExp);
        checkOutput("err_last", err_last, lastExp);
        checkOutput("err_range", err_range, rangeExp);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (expQ.size() > 0 || zModel.size() > 0); i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
        end
        checkOutput("drain_pending", expQ.size() + zModel.size(), 0);
    endtask

    task automatic doReset();
        s_rst_n = 1'b0;
        z_vld = 1'b0; z = '0; z_last = 1'b0;
        e_vld = 1'b0; e = '0; e_last = 1'b0;
        c_rdy = 1'b1;
        #1;
        checkOutput("rst_c_vld", c_vld, 0);
        checkOutput("rst_c", c, 0);
        checkOutput("rst_c_last", c_last, 0);
        checkOutput("rst_z_rdy", z_rdy, 1);
        checkOutput("rst_e_rdy", e_rdy, 0);
        checkOutput("rst_err_ovf", err_ovf, 0);
        checkOutput("rst_err_last", err_last, 0);
        checkOutput("rst_err_range", err_range, 0);
        zModel.delete();
        expQ.delete();
        ePendV.delete();
        ePendL.delete();
        fireIdx = 0;
        ovfExp = 1'b0;
        lastExp = 1'b0;
        rangeExp = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        int            zi;
        bit            sendZ;
        logic [QW-1:0] zr;
        s_rst_n = 1'b1;
        z_vld = 1'b0; z = '0; z_last = 1'b0;
        e_vld = 1'b0; e = '0; e_last = 1'b0;
        c_rdy = 1'b1;
        #1;
        doReset();

        $display("[TB] aligned polynomial");
        eEn = 1'b1;
        latChk = 1'b1;
        pushE(1, 0); pushE(2, 0); pushE(3, 0); pushE(4, 1);
        applyStimulus(1'b1, 8'd10, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd20, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd30, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd40, 1'b1, 1'b1);
        drain();

        $display("[TB] modular wrap");
        pushE(250, 0); pushE(51, 0); pushE(0, 0); pushE(7, 1);
        applyStimulus(1'b1, 8'd250, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd200, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd5, 1'b1, 1'b1);
        drain();
        latChk = 1'b0;

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3 * N; k++) pushE($urandom_range(0, Q - 1), (k % N) == N - 1);
        zi = 0;
        for (int t = 0; t < 300 && (zi < 3 * N || expQ.size() > 0 || zModel.size() > 0); t++) begin
            sendZ = (zi < 3 * N) && (zModel.size() < N) && ($urandom_range(0, 3) != 0);
            zr = sendZ ? QW'($urandom_range(0, Q - 1)) : '0;
            applyStimulus(sendZ, zr, sendZ && ((zi % N) == N - 1), $urandom_range(0, 2) != 0);
            if (sendZ) zi++;
        end
        checkOutput("rand_z_sent", zi, 3 * N);
        checkOutput("rand_pending", expQ.size() + zModel.size(), 0);

        $display("[TB] backpressure");
        eEn = 1'b0;
        pushE(5, 0); pushE(6, 0); pushE(7, 0); pushE(8, 1);
        applyStimulus(1'b1, 8'd100, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd101, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd102, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd103, 1'b1, 1'b1);
        checkOutput("bp_full_z_rdy", z_rdy, 0);
        eEn = 1'b1;
        for (int t = 0; t < 16; t++) applyStimulus(1'b0, '0, 1'b0, (t % 3) == 0);
        drain();

        $display("[TB] overflow");
        eEn = 1'b0;
        pushE(9, 0); pushE(10, 0); pushE(11, 0); pushE(12, 1);
        applyStimulus(1'b1, 8'd60, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd61, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd62, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd63, 1'b1, 1'b1);
        checkOutput("ovf_before", err_ovf, 0);
        applyStimulus(1'b1, 8'd64, 1'b0, 1'b1);
        checkOutput("ovf_after", err_ovf, 1);
        eEn = 1'b1;
        drain();

        $display("[TB] misaligned z_last");
        checkOutput("mis_before", err_last, 0);
        pushE(1, 0); pushE(1, 0); pushE(1, 0); pushE(1, 1);
        applyStimulus(1'b1, 8'd70, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd71, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd72, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd73, 1'b0, 1'b1);
        drain();
        checkOutput("mis_after", err_last, 1);

        $display("[TB] input range");
        pushE(251, 0); pushE(1, 0); pushE(1, 0); pushE(1, 1);
        applyStimulus(1'b1, 8'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd3, 1'b1, 1'b1);
        drain();
`ifdef CT_INPUT_RANGE_CHK_EN
        checkOutput("range_flag", err_range, 1);
`else
        checkOutput("range_flag", err_range, 0);
`endif

        $display("[TB] reset mid-polynomial");
        doReset();
        eEn = 1'b0;
        pushE(1, 0); pushE(2, 0); pushE(3, 0); pushE(4, 1);
        applyStimulus(1'b1, 8'd50, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd51, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd52, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd53, 1'b1, 1'b1);
        eEn = 1'b1;
        for (int t = 0; t < 10 && fireIdx < 2; t++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("rst_two_fired", fireIdx, 2);
        doReset();
        latChk = 1'b1;
        pushE(5, 0); pushE(6, 0); pushE(7, 0); pushE(8, 1);
        applyStimulus(1'b1, 8'd90, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd91, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd92, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd93, 1'b1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
